ldpc_wb_sched: RTL and testbench

Wishbone-slave controller that sequences the LDPC encoder/decoder datapath inside the user project wrapper. Firmware loads a codeword, selects encode or decode, and writes GO. The block then drives the datapath start/step handshakes and bounds decode iterations and wait time. It reports the result in a status register, on a 16-bit GPIO status word (mprj_io[31:16]) and on an optional interrupt.

---
 rtl/ldpc_wb_sched.sv | 177 +++++++++++++++++
 tb/tb_ldpc_wb_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_wb_sched.sv
// ldpc_wb_sched: Wishbone-controlled LDPC encode/decode sequencer; define LDPC_SCHED_IRQ_EN for the completion interrupt
module ldpc_wb_sched #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int CW_WORDS = 4,
  parameter int MAX_ITER = 15,
  parameter int ITER_W = 4,
  parameter int TIMEOUT_W = 12
) (
  input  logic                   wb_clk_i,
  input  logic                   resetb,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [32*CW_WORDS-1:0] cw_o,
  output logic                   mode_o,
  output logic                   start_o,
  output logic                   step_o,
  input  logic                   done_i,
  input  logic                   synd_zero_i,
  input  logic [32*CW_WORDS-1:0] res_i,
  output logic [15:0]            status_o,
  output logic                   irq_o
);
  localparam int CW = 32*CW_WORDS;
  localparam int AW = CW_WORDS > 1 ? $clog2(CW_WORDS) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT_E, STEP, WAIT_D, DONE} state_t;
  state_t state_q;
  logic ack_q, mode_q, run_mode_q, start_q, step_q, pass_q, fail_q, tout_q, irq_bit;
  logic [31:0] dat_q, wmask, cw_old, rdata;
  logic [3:0] iter_q, iter_d, woff, cwi;
  logic [AW-1:0] wi;
  logic [CW-1:0] in_q, res_q;
  logic [ITER_W-1:0] lim_q, lim_d, cnt_q;
  logic [TIMEOUT_W-1:0] to_q;
  logic [15:0] status_q;
  logic in_win, acc, wr, idle, is_ctrl, is_stat, is_cw, go, mode_d, clr_en;
  assign in_win  = wbs_adr_i >= BASE_ADDR && wbs_adr_i <= BASE_ADDR + 32'h3F;
  assign acc     = wbs_cyc_i & wbs_stb_i & in_win & ~ack_q;
  assign wr      = acc & wbs_we_i;
  assign idle    = state_q == IDLE;
  assign woff    = wbs_adr_i[5:2] - BASE_ADDR[5:2];
  assign cwi     = woff - 4'd4;
  assign wi      = cwi[AW-1:0];
  assign is_ctrl = woff == 4'd0;
  assign is_stat = woff == 4'd1;
  assign is_cw   = woff >= 4'd4 && int'(cwi) < CW_WORDS;
  assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign cw_old  = in_q[{wi, 5'd0} +: 32];
  assign mode_d  = wbs_sel_i[0] ? wbs_dat_i[1] : mode_q;
  assign iter_d  = wbs_sel_i[0] ? wbs_dat_i[7:4] : iter_q;
  assign lim_d   = iter_d == 4'd0 ? ITER_W'(MAX_ITER) : ITER_W'(iter_d);
  assign go      = wr & is_ctrl & idle & wbs_sel_i[0] & wbs_dat_i[0];
  assign clr_en  = wr & is_stat & wbs_sel_i[0];
  assign rdata   = is_ctrl ? {24'd0, iter_q, 2'd0, mode_q, 1'b0}
                 : is_stat ? {20'd0, 4'(cnt_q), 3'd0, irq_bit, tout_q, fail_q, pass_q, ~idle}
                 : is_cw   ? res_q[{wi, 5'd0} +: 32] : 32'd0;
`ifdef LDPC_SCHED_IRQ_EN
  logic irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign cw_o      = in_q;
  assign mode_o    = run_mode_q;
  assign start_o   = start_q;
  assign step_o    = step_q;
  assign status_o  = status_q;
  assign irq_o     = irq_bit;
  // Wishbone slave: single-cycle ack with a forced gap, config and input buffer writes only while idle
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'd0;
      mode_q <= 1'b0;
      iter_q <= 4'd0;
      in_q   <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= acc ? rdata : 32'd0;
      if (wr && idle && is_ctrl) begin
        mode_q <= mode_d;
        iter_q <= iter_d;
      end
      if (wr && idle && is_cw) in_q[{wi, 5'd0} +: 32] <= (cw_old & ~wmask) | (wbs_dat_i & wmask);
    end
  end
  // Sequencer: start/step handshakes, iteration and timeout bounds, sticky status (sets win over clears)
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      run_mode_q <= 1'b0;
      start_q    <= 1'b0;
      step_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tout_q     <= 1'b0;
      lim_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      res_q      <= '0;
      status_q   <= 16'h0000;
`ifdef LDPC_SCHED_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      step_q  <= 1'b0;
      if (clr_en && wbs_dat_i[1]) pass_q <= 1'b0;
      if (clr_en && wbs_dat_i[2]) fail_q <= 1'b0;
      if (clr_en && wbs_dat_i[3]) tout_q <= 1'b0;
`ifdef LDPC_SCHED_IRQ_EN
      if (clr_en && wbs_dat_i[4]) irq_q <= 1'b0;
`endif
      case (state_q)
        IDLE:
          if (go) begin
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tout_q     <= 1'b0;
            cnt_q      <= '0;
            run_mode_q <= mode_d;
            lim_q      <= lim_d;
            start_q    <= 1'b1;
            status_q   <= 16'hAB60;
            state_q    <= START;
          end
        START: begin
          to_q    <= '0;
          step_q  <= ~run_mode_q;
          state_q <= run_mode_q ? WAIT_E : STEP;
        end
        STEP: begin
          cnt_q   <= &cnt_q ? cnt_q : cnt_q + 1'b1;
          to_q    <= '0;
          state_q <= WAIT_D;
        end
        WAIT_E, WAIT_D:
          if (done_i) begin
            res_q <= res_i;
            if (state_q == WAIT_E || synd_zero_i) begin
              pass_q   <= 1'b1;
              status_q <= 16'hFFF6;
              state_q  <= DONE;
            end else if (cnt_q == lim_q) begin
              fail_q   <= 1'b1;
              status_q <= 16'hFFF4;
              state_q  <= DONE;
            end else begin
              step_q  <= 1'b1;
              state_q <= STEP;
            end
          end else if (&to_q) begin
            tout_q   <= 1'b1;
            fail_q   <= 1'b1;
            status_q <= 16'hFFF4;
            state_q  <= DONE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        DONE: begin
`ifdef LDPC_SCHED_IRQ_EN
          irq_q <= 1'b1;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldpc_wb_sched.sv
// tb_ldpc_wb_sched: scoreboard bench for the LDPC Wishbone scheduler with a behavioural datapath responder
module tb_ldpc_wb_sched;
  localparam logic [31:0] B = 32'h3000_0000;
`ifdef LDPC_SCHED_IRQ_EN
  localparam logic [31:0] IRQB = 32'h10;
`else
  localparam logic [31:0] IRQB = 32'h0;
`endif
  logic clk = 1'b0, resetb = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = 32'd0, wdat = 32'd0, rdat;
  logic ack, mode_o, start_o, step_o, irq_o;
  logic done_i, synd_zero_i;
  logic [127:0] cw_o, res_i, res_pat;
  logic [15:0] status_o;
  logic [31:0] sb_q[$];
  logic [31:0] w[4];
  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_step = 0, ndone = 0;
  int resp_dly = 3, synd_at = -1;
  logic resp_en = 1'b0, prev_ack = 1'b0;

  always #5 clk = ~clk;

  ldpc_wb_sched dut (
    .wb_clk_i(clk), .resetb(resetb),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cw_o(cw_o), .mode_o(mode_o), .start_o(start_o), .step_o(step_o),
    .done_i(done_i), .synd_zero_i(synd_zero_i), .res_i(res_i),
    .status_o(status_o), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rw(input int i, input int k);
    logic [127:0] v;
    v = res_pat ^ {4{32'(k)}};
    return v[32*i +: 32];
  endfunction

  // Datapath model: answers encode starts and decode steps after resp_dly cycles
  initial begin
    done_i = 1'b0;
    synd_zero_i = 1'b0;
    res_i = '0;
    forever begin
      @(negedge clk);
      done_i = 1'b0;
      synd_zero_i = 1'b0;
      if (resp_en && ((start_o && mode_o) || step_o)) begin
        ndone++;
        repeat (resp_dly - 1) @(negedge clk);
        done_i = 1'b1;
        synd_zero_i = (ndone == synd_at);
        res_i = res_pat ^ {4{32'(ndone)}};
      end
    end
  end

  // Pulse counters and back-to-back ack monitor
  always @(negedge clk) begin
    if (start_o) n_start++;
    if (step_o) n_step++;
    if (ack) check("ack_gap", 32'(prev_ack), 32'd0);
    prev_ack = ack;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wb_cycle(input logic w_e, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic acked);
    cyc = 1'b1; stb = 1'b1; we = w_e; adr = a; wdat = d; sel = s;
    acked = 1'b0; rd = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd;
    logic acked;
    wb_cycle(1'b1, a, d, s, rd, acked);
    check("wr_ack", 32'(acked), 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd, e;
    logic acked;
    sb_q.push_back(exp);
    wb_cycle(1'b0, a, 32'd0, 4'hF, rd, acked);
    e = sb_q.pop_front();
    check({tag, "_ack"}, 32'(acked), 32'd1);
    if (acked) check(tag, rd, e);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (status_o == 16'hAB60 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 32'(status_o != 16'hAB60), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_dat"}, rdat, 32'd0);
    check({tag, "_cw"}, 32'(|cw_o), 32'd0);
    check({tag, "_mode"}, 32'(mode_o), 32'd0);
    check({tag, "_start"}, 32'(start_o), 32'd0);
    check({tag, "_step"}, 32'(step_o), 32'd0);
    check({tag, "_gpio"}, 32'(status_o), 32'd0);
    check({tag, "_irq"}, 32'(irq_o), 32'd0);
  endtask

  initial begin
    int n, d0, s0, t0;
    logic [31:0] rd;
    logic acked;
    res_pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    for (int i = 0; i < 4; i++) w[i] = 32'hC0DE_0000 + 32'(i) * 32'h1111;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetb = 1'b1;
    @(negedge clk);
    wb_read("rst_ctrl", B, 32'd0);
    wb_read("rst_stat", B + 4, 32'd0);
    for (int i = 0; i < 4; i++) wb_write(B + 16 + 4 * i, w[i]);
    for (int i = 0; i < 4; i++) check("cw_load", cw_o[32*i +: 32], w[i]);
    wb_write(B + 16, 32'hFFFF_FFFF, 4'b0010);
    check("byte_sel", cw_o[31:0], 32'hC0DE_FF00);
    wb_write(B + 16, w[0]);
    wb_read("unmapped08", B + 8, 32'd0);
    wb_read("unmapped3c", B + 32'h3C, 32'd0);
    wb_cycle(1'b0, B + 32'h40, 32'd0, 4'hF, rd, acked);
    check("oow_hi_noack", 32'(acked), 32'd0);
    wb_cycle(1'b1, B - 4, 32'd0, 4'hF, rd, acked);
    check("oow_lo_noack", 32'(acked), 32'd0);
    // encode
    resp_en = 1'b1; resp_dly = 5; d0 = ndone; s0 = n_start; t0 = n_step;
    wb_write(B, 32'h3);
    check("enc_gpio_busy", 32'(status_o), 32'hAB60);
    check("enc_mode", 32'(mode_o), 32'd1);
    wb_read("enc_busy", B + 4, 32'h001);
    wait_done(100, n);
    check("enc_gpio_pass", 32'(status_o), 32'hFFF6);
    @(negedge clk);
    wb_read("enc_stat", B + 4, 32'h002 | IRQB);
    check("enc_starts", 32'(n_start - s0), 32'd1);
    check("enc_steps", 32'(n_step - t0), 32'd0);
    check("enc_irq", 32'(irq_o), 32'(IRQB[4]));
    for (int i = 0; i < 4; i++) wb_read("enc_res", B + 16 + 4 * i, rw(i, d0 + 1));
    wb_read("enc_ctrl", B, 32'h2);
    wb_write(B + 4, 32'h1E);
    wb_read("clr1", B + 4, 32'd0);
    check("clr1_irq", 32'(irq_o), 32'd0);
    // decode converging on the 3rd iteration
    resp_dly = 3; d0 = ndone; synd_at = d0 + 3; s0 = n_start; t0 = n_step;
    wb_write(B, 32'h41);
    check("conv_mode", 32'(mode_o), 32'd0);
    wait_done(200, n);
    check("conv_gpio", 32'(status_o), 32'hFFF6);
    @(negedge clk);
    check("conv_steps", 32'(n_step - t0), 32'd3);
    check("conv_starts", 32'(n_start - s0), 32'd1);
    wb_read("conv_stat", B + 4, 32'h302 | IRQB);
    wb_read("conv_res", B + 16, rw(0, d0 + 3));
    wb_read("conv_ctrl", B, 32'h40);
    wb_write(B + 4, 32'h1E);
    // decode hitting MAX_ITER
    d0 = ndone; synd_at = -1; t0 = n_step;
    wb_write(B, 32'h1);
    wait_done(2000, n);
    check("fail_gpio", 32'(status_o), 32'hFFF4);
    @(negedge clk);
    check("fail_steps", 32'(n_step - t0), 32'd15);
    wb_read("fail_stat", B + 4, 32'hF04 | IRQB);
    wb_read("fail_res", B + 28, rw(3, d0 + 15));
    wb_write(B + 4, 32'h1E);
    d0 = d0 + 15;
    // timeout in WAIT_D
    resp_en = 1'b0; t0 = n_step;
    wb_write(B, 32'h1);
    wait_done(5000, n);
    check("to_cycles", 32'(n), 32'd4098);
    check("to_gpio", 32'(status_o), 32'hFFF4);
    @(negedge clk);
    check("to_steps", 32'(n_step - t0), 32'd1);
    wb_read("to_stat", B + 4, 32'h10C | IRQB);
    check("to_irq", 32'(irq_o), 32'(IRQB[4]));
    wb_read("to_res_kept", B + 16, rw(0, d0));
    wb_write(B + 4, 32'h1E);
    wb_read("to_clr", B + 4, 32'h100);
    // writes while busy
    s0 = n_start;
    wb_write(B, 32'h1);
    wb_write(B + 16, 32'hDEAD_BEEF);
    check("busy_cw", cw_o[31:0], w[0]);
    wb_write(B, 32'h3);
    check("busy_mode", 32'(mode_o), 32'd0);
    wb_read("busy_ctrl", B, 32'd0);
    wait_done(5000, n);
    @(negedge clk);
    check("busy_starts", 32'(n_start - s0), 32'd1);
    wb_write(B + 4, 32'h1E);
    wb_read("busy_clr", B + 4, 32'h100);
    // reset in the middle of a decode
    resp_en = 1'b1; resp_dly = 3; synd_at = -1;
    wb_write(B, 32'h1);
    repeat (10) @(negedge clk);
    #2 resetb = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    resp_en = 1'b0;
    resetb = 1'b1;
    repeat (4) @(negedge clk);
    wb_read("midrst_stat", B + 4, 32'd0);
    wb_read("midrst_ctrl", B, 32'd0);
    check("midrst_gpio", 32'(status_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
